password_programmer: RTL and testbench

- Enrollment (writer) side of the switch-password lock: the user enters a new 4-step switch sequence on the same 10 slide switches, and the block stores it.
- The checker reads the stored sequence from `seq_code`.
- Progress is shown on `leds`, entered digits on HEX3..HEX0, and mode on HEX4.
- Lives beside the checker in the board top level; both share `codigo`, `clk` (50 MHz) and `rst`.

---
 rtl/password_programmer.sv | 182 ++++++++++++++++++
 tb/tb_password_programmer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/password_programmer.sv
// Enrollment side of the switch-password lock: captures a 4-step switch
// sequence on debounced sample ticks and commits it to seq_code.
module password_programmer #(
  parameter int unsigned DIV         = 50000,
  parameter logic [15:0] DEFAULT_SEQ = 16'h0271
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_en,
  input  logic [9:0]  codigo,
  output logic [15:0] seq_code,
  output logic        seq_update,
  output logic [3:0]  leds,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CLEAR, S_ENTRY, S_DONE, S_ERROR
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [9:0]      codigo_s1_q, codigo_s1_d, codigo_s2_q, codigo_s2_d;
  logic            prog_s1_q, prog_s1_d, prog_s2_q, prog_s2_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      cur_q, cur_d, prev_q, prev_d;
  logic            evt_q, evt_d;
  state_t          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     seq_q, seq_d;
  logic            upd_q, upd_d;
  logic [3:0]      leds_q, leds_d;
  logic [4:0][6:0] hex_q, hex_d;

  logic            tick;
  logic [9:0]      rise, fall;
  logic [3:0]      rise_idx;

  always_comb begin
    codigo_s1_d = codigo;
    codigo_s2_d = codigo_s1_q;
    prog_s1_d   = prog_en;
    prog_s2_d   = prog_s1_q;
    tick        = (cnt_q == CW'(DIV - 1));
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    cur_d       = tick ? codigo_s2_q : cur_q;
    prev_d      = tick ? cur_q : prev_q;
    evt_d       = tick;
    rise        = cur_q & ~prev_q;
    fall        = prev_q & ~cur_q;
    rise_idx    = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (rise[i]) rise_idx = 4'(i);
    end
  end

  // Abort is checked every clk and overrides anything the sample tick would do.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    seq_d    = seq_q;
    upd_d    = 1'b0;
    leds_d   = leds_q;
    hex_d    = hex_q;
    if (state_q != S_IDLE && !prog_s2_q) begin
      state_d  = S_IDLE;
      k_d      = '0;
      shadow_d = '0;
      leds_d   = '0;
      hex_d    = '1;
    end else if (evt_q) begin
      case (state_q)
        S_IDLE: begin
          if (prog_s2_q) begin
            state_d  = S_WAIT_CLEAR;
            hex_d[4] = SEG_P;
          end
        end
        S_WAIT_CLEAR: begin
          if (cur_q == '0) begin
            state_d  = S_ENTRY;
            k_d      = '0;
            shadow_d = '0;
          end
        end
        S_ENTRY: begin
          if (fall != '0 || $countones(rise) > 1) begin
            state_d  = S_ERROR;
            leds_d   = 4'b1010;
            hex_d[4] = SEG_E;
          end else if (rise != '0) begin
            shadow_d[{k_q, 2'b00} +: 4] = rise_idx;
            leds_d[k_q]                 = 1'b1;
            hex_d[{1'b0, k_q}]          = seg7(rise_idx);
            if (k_q == 2'd3) begin
              state_d  = S_DONE;
              seq_d    = shadow_d;
              upd_d    = 1'b1;
              hex_d[4] = SEG_D;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      codigo_s1_q <= '0;
      codigo_s2_q <= '0;
      prog_s1_q   <= 1'b0;
      prog_s2_q   <= 1'b0;
      cnt_q       <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      evt_q       <= 1'b0;
      state_q     <= S_IDLE;
      k_q         <= '0;
      shadow_q    <= '0;
      seq_q       <= DEFAULT_SEQ;
      upd_q       <= 1'b0;
      leds_q      <= '0;
      hex_q       <= '1;
    end else begin
      codigo_s1_q <= codigo_s1_d;
      codigo_s2_q <= codigo_s2_d;
      prog_s1_q   <= prog_s1_d;
      prog_s2_q   <= prog_s2_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      evt_q       <= evt_d;
      state_q     <= state_d;
      k_q         <= k_d;
      shadow_q    <= shadow_d;
      seq_q       <= seq_d;
      upd_q       <= upd_d;
      leds_q      <= leds_d;
      hex_q       <= hex_d;
    end
  end

  assign seq_code   = seq_q;
  assign seq_update = upd_q;
  assign leds       = leds_q;
  assign HEX0       = hex_q[0];
  assign HEX1       = hex_q[1];
  assign HEX2       = hex_q[2];
  assign HEX3       = hex_q[3];
  assign HEX4       = hex_q[4];

endmodule

// File: tb/tb_password_programmer.sv
// Randomized bench for password_programmer against a switch-transition level
// model of the enrollment rules.
module tb_password_programmer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_en = 1'b0;
  logic [9:0]  codigo = '0;
  logic [15:0] seq_code;
  logic        seq_update;
  logic [3:0]  leds;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;

  password_programmer #(.DIV(4), .DEFAULT_SEQ(16'h0271)) dut (
    .clk(clk), .rst(rst), .prog_en(prog_en), .codigo(codigo),
    .seq_code(seq_code), .seq_update(seq_update), .leds(leds),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_WAIT = 1, M_ENTRY = 2, M_DONE = 3, M_ERR = 4;
  logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_mode;
  int          m_n;
  int          m_dig [4];
  logic [15:0] m_seq;
  int          m_commits = 0;
  int          pulses = 0;
  int          long_pulses = 0;
  logic        upd_prev = 1'b0;

  always @(posedge clk) begin
    if (seq_update) pulses <= pulses + 1;
    if (seq_update && upd_prev) long_pulses <= long_pulses + 1;
    upd_prev <= seq_update;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_n    = 0;
    m_seq  = 16'h0271;
  endtask

  // Each call represents one isolated switch/enable change after it has settled.
  task automatic model_step(input logic [9:0] oc, input logic [9:0] nc, input logic np);
    logic [9:0] r, f;
    int idx;
    if (!np) begin
      m_mode = M_IDLE;
      m_n    = 0;
      return;
    end
    if (m_mode == M_IDLE) m_mode = M_WAIT;
    if (m_mode == M_WAIT) begin
      if (nc == 0) begin
        m_mode = M_ENTRY;
        m_n    = 0;
      end
    end else if (m_mode == M_ENTRY && nc != oc) begin
      r = nc & ~oc;
      f = oc & ~nc;
      if (f != 0 || $countones(r) > 1) begin
        m_mode = M_ERR;
      end else begin
        idx = 0;
        for (int i = 0; i < 10; i++) if (r[i]) idx = i;
        m_dig[m_n] = idx;
        m_n++;
        if (m_n == 4) begin
          m_mode = M_DONE;
          m_seq  = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
          m_commits++;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_leds();
    case (m_mode)
      M_ENTRY: return 4'((1 << m_n) - 1);
      M_DONE:  return 4'b1111;
      M_ERR:   return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(input int j);
    if (j == 4) begin
      case (m_mode)
        M_WAIT, M_ENTRY: return 7'b0001100;
        M_DONE:          return 7'b0100001;
        M_ERR:           return 7'b0000110;
        default:         return 7'b1111111;
      endcase
    end
    if (m_mode != M_IDLE && m_mode != M_WAIT && j < m_n) return segtab[m_dig[j]];
    return 7'b1111111;
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ":leds"}, 32'(leds), 32'(exp_leds()));
    check({ctx, ":seq_code"}, 32'(seq_code), 32'(m_seq));
    check({ctx, ":HEX0"}, 32'(HEX0), 32'(exp_hex(0)));
    check({ctx, ":HEX1"}, 32'(HEX1), 32'(exp_hex(1)));
    check({ctx, ":HEX2"}, 32'(HEX2), 32'(exp_hex(2)));
    check({ctx, ":HEX3"}, 32'(HEX3), 32'(exp_hex(3)));
    check({ctx, ":HEX4"}, 32'(HEX4), 32'(exp_hex(4)));
    check({ctx, ":update_count"}, 32'(pulses), 32'(m_commits));
  endtask

  task automatic apply(input string ctx, input logic [9:0] nc, input logic np);
    logic [9:0] oc;
    oc      = codigo;
    codigo  = nc;
    prog_en = np;
    repeat (20) @(posedge clk);
    #1;
    model_step(oc, nc, np);
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    rst = 1'b0;
    #30;
    model_reset();
    check_all({ctx, ":in_reset"});
    check({ctx, ":upd_in_reset"}, 32'(seq_update), 32'd0);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    model_step(codigo, codigo, prog_en);
    check_all({ctx, ":after"});
  endtask

  initial begin
    logic [9:0] nc;
    logic       np;
    int         r, b1, b2;

    model_reset();
    #23;
    check_all("reset");
    check("reset:seq_update", 32'(seq_update), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    apply("t2_en", 10'h000, 1'b1);
    apply("t2_s0", 10'h008, 1'b1);
    apply("t2_s1", 10'h028, 1'b1);
    apply("t2_s2", 10'h228, 1'b1);
    apply("t2_s3", 10'h229, 1'b1);
    check("t2:seq_const", 32'(seq_code), 32'h0953);
    check("t2:one_pulse", 32'(pulses), 32'd1);

    apply("t3_off", 10'h229, 1'b0);
    apply("t3_clr", 10'h000, 1'b0);
    apply("t3_en", 10'h000, 1'b1);
    apply("t3_s0", 10'h002, 1'b1);
    apply("t3_two", 10'h052, 1'b1);
    check("t3:leds_const", 32'(leds), 32'hA);

    apply("t4_off", 10'h000, 1'b0);
    apply("t4_en", 10'h000, 1'b1);
    apply("t4_s0", 10'h002, 1'b1);
    apply("t4_drop", 10'h000, 1'b1);
    apply("t4_off2", 10'h000, 1'b0);

    apply("t5_pre", 10'h004, 1'b0);
    apply("t5_en", 10'h004, 1'b1);
    apply("t5_clr", 10'h000, 1'b1);

    apply("t6_s0", 10'h001, 1'b1);
    apply("t6_s1", 10'h003, 1'b1);
    apply("t6_s2", 10'h007, 1'b1);
    do_reset("t6_rst");

    apply("ab_clr", 10'h000, 1'b1);
    apply("ab_s0", 10'h001, 1'b1);
    apply("ab_s1", 10'h003, 1'b1);
    apply("ab_s2", 10'h007, 1'b1);
    apply("ab_s3", 10'h00F, 1'b0);

    for (int op = 0; op < 250; op++) begin
      nc = codigo;
      np = prog_en;
      r  = int'($urandom_range(0, 99));
      b1 = int'($urandom_range(0, 9));
      if (r < 3) begin
        do_reset("rnd_rst");
        continue;
      end else if (r < 12) np = ~prog_en;
      else if (r < 18) nc = '0;
      else if (r < 26) begin
        b2 = (b1 + 1 + int'($urandom_range(0, 8))) % 10;
        nc = codigo ^ (10'd1 << b1) ^ (10'd1 << b2);
      end else if (r < 32) nc = codigo & ~(10'd1 << b1);
      else nc = codigo | (10'd1 << b1);
      apply("rnd", nc, np);
    end

    check("end:long_pulses", 32'(long_pulses), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
